// File: rtl/dcpu_pkg.sv
// Shared dcpu definitions: address-mode encodings, fetch FSM states and the
// instruction length / immediate decode helpers used by fetch and the core decoder.
package dcpu_pkg;

    localparam logic [2:0] AMODE_NOIM = 3'b000;
    localparam logic [2:0] AMODE_IM12 = 3'b001;
    localparam logic [2:0] AMODE_IM28 = 3'b010;
    localparam logic [2:0] AMODE_IM32 = 3'b011;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBus   = 2'd1,
        StError = 2'd2
    } fetch_state_e;

    // Instruction length in halfwords; reserved modes 100-111 behave as NOIM.
    function automatic logic [1:0] amode_length(input logic [2:0] amode);
        case (amode)
            AMODE_IM12:             return 2'd2;
            AMODE_IM28, AMODE_IM32: return 2'd3;
            default:                return 2'd1;
        endcase
    endfunction

    // imm = hw1:hw2; IM12 and IM28 both take their sign from imm bit 27 (hw1[11]).
    function automatic logic [31:0] decode_immediate(input logic [2:0]  amode,
                                                     input logic [15:0] hw1,
                                                     input logic [15:0] hw2);
        case (amode)
            AMODE_IM12: return {{20{hw1[11]}}, hw1[11:0]};
            AMODE_IM28: return {{4{hw1[11]}}, hw1[11:0], hw2};
            AMODE_IM32: return {hw1, hw2};
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/hw_queue.sv
// Halfword FIFO: pushes one or two halfwords, pops one to three, and exposes
// the three oldest entries so the head instruction can be decoded in place.
module hw_queue
    import dcpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [1:0]               i_push_n,
    input  logic [15:0]              i_push_hw0,
    input  logic [15:0]              i_push_hw1,
    input  logic [1:0]               i_pop_n,
    output logic [15:0]              o_hw0,
    output logic [15:0]              o_hw1,
    output logic [15:0]              o_hw2,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic [PW-1:0] w_wr1;
    logic [PW-1:0] w_rd1;
    logic [PW-1:0] w_rd2;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign w_wr1 = r_wr + PW'(1);
    assign w_rd1 = r_rd + PW'(1);
    assign w_rd2 = r_rd + PW'(2);

    // Storage and pointer update; push and pop in the same cycle both apply.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push_n != 2'd0) begin
                r_mem[r_wr] <= i_push_hw0;
            end
            if (i_push_n == 2'd2) begin
                r_mem[w_wr1] <= i_push_hw1;
            end
            r_wr    <= r_wr + PW'(i_push_n);
            r_rd    <= r_rd + PW'(i_pop_n);
            r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
        end
    end

    assign o_hw0   = r_mem[r_rd];
    assign o_hw1   = r_mem[w_rd1];
    assign o_hw2   = r_mem[w_rd2];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetcher.sv
// Instruction prefetcher: streams big-endian words from Wishbone into a halfword
// queue and presents the decoded head instruction; handles redirect and bus errors.
module fetch_prefetcher
    import dcpu_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic [AW-1:0] o_wb_addr,
    output logic          o_wb_cyc,
    output logic [3:0]    o_wb_stb,
    output logic          o_wb_we,
    output logic [31:0]   o_wb_dat,
    input  logic [31:0]   i_wb_dat,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_pc,
    input  logic          i_take,
    output logic          o_valid,
    output logic [15:0]   o_instruction,
    output logic [31:0]   o_immediate,
    output logic [3:0]    o_rb_idx,
    output logic          o_rb_idx_valid,
    output logic [AW-1:0] o_pc,
    output logic [AW-1:0] o_next_pc,
    output logic          o_error
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_d;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] w_fetch_pc_d;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_d;
    logic          r_armed;
    logic          w_armed_d;

    logic          w_flush;
    logic [1:0]    w_push_n;
    logic [15:0]   w_push_hw0;
    logic [1:0]    w_pop_n;
    logic [15:0]   w_hw0;
    logic [15:0]   w_hw1;
    logic [15:0]   w_hw2;
    logic [CW-1:0] w_count;

    logic [2:0]    w_amode;
    logic [1:0]    w_len;
    logic          w_valid;
    logic          w_free_ok;
    logic [AW-1:0] w_next_word;
    logic [AW-1:0] w_redirect_pc;
    logic          w_unused;

    hw_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_flush),
        .i_push_n   (w_push_n),
        .i_push_hw0 (w_push_hw0),
        .i_push_hw1 (i_wb_dat[15:0]),
        .i_pop_n    (w_pop_n),
        .o_hw0      (w_hw0),
        .o_hw1      (w_hw1),
        .o_hw2      (w_hw2),
        .o_count    (w_count)
    );

    assign w_amode       = w_hw0[2:0];
    assign w_len         = amode_length(w_amode);
    assign w_valid       = w_count >= CW'(w_len);
    // At most two halfwords arrive per bus cycle, so two free slots keep count <= DEPTH.
    assign w_free_ok     = w_count <= CW'(DEPTH - 2);
    assign w_next_word   = r_fetch_pc + AW'(4);
    assign w_redirect_pc = {i_redirect_pc[AW-1:1], 1'b0};
    assign w_unused      = i_redirect_pc[0];
    // An odd fetch address only wants the low (later) halfword of the word.
    assign w_push_hw0    = r_fetch_pc[1] ? i_wb_dat[15:0] : i_wb_dat[31:16];

    // State, fetch address and presented-pc registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_fetch_pc <= '0;
            r_pc       <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_pc       <= w_pc_d;
            r_armed    <= w_armed_d;
        end
    end

    // Bus FSM next state plus queue push/pop control; redirect overrides everything.
    always_comb begin
        w_state_d    = r_state;
        w_fetch_pc_d = r_fetch_pc;
        w_pc_d       = r_pc;
        w_armed_d    = r_armed;
        w_flush      = 1'b0;
        w_push_n     = 2'd0;
        w_pop_n      = 2'd0;
        if (i_redirect) begin
            w_flush      = 1'b1;
            w_pc_d       = w_redirect_pc;
            w_fetch_pc_d = w_redirect_pc;
            w_armed_d    = 1'b1;
            // An outstanding cycle must be dropped before a new one can start.
            w_state_d    = (r_state == StBus) ? StIdle : StBus;
        end else begin
            if (i_take && w_valid) begin
                w_pop_n = w_len;
                w_pc_d  = r_pc + AW'({w_len, 1'b0});
            end
            case (r_state)
                StIdle: begin
                    if (r_armed && w_free_ok) begin
                        w_state_d = StBus;
                    end
                end
                StBus: begin
                    if (i_wb_err) begin
                        w_state_d = StError;
                    end else if (i_wb_ack) begin
                        w_push_n     = r_fetch_pc[1] ? 2'd1 : 2'd2;
                        w_fetch_pc_d = {w_next_word[AW-1:2], 2'b00};
                        w_state_d    = StIdle;
                    end
                end
                StError: begin
                    w_state_d = StError;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    assign o_wb_cyc  = (r_state == StBus);
    assign o_wb_addr = {r_fetch_pc[AW-1:2], 2'b00};
    assign o_wb_stb  = !o_wb_cyc ? 4'b0000 : (r_fetch_pc[1] ? 4'b0011 : 4'b1111);
    assign o_wb_we   = 1'b0;
    assign o_wb_dat  = 32'd0;

    // Decode outputs are forced to zero while no complete instruction is queued.
    assign o_valid        = w_valid;
    assign o_instruction  = w_valid ? w_hw0 : 16'd0;
    assign o_immediate    = w_valid ? decode_immediate(w_amode, w_hw1, w_hw2) : 32'd0;
    assign o_rb_idx       = w_valid ? w_hw1[15:12] : 4'd0;
    assign o_rb_idx_valid = w_valid && ((w_amode == AMODE_IM12) || (w_amode == AMODE_IM28));
    assign o_pc           = r_pc;
    assign o_next_pc      = w_valid ? (r_pc + AW'({w_len, 1'b0})) : '0;
    assign o_error        = (r_state == StError) && !w_valid;

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Self-checking bench for fetch_prefetcher: directed scenarios plus a randomized
// stream compared against a memory-walking reference model.
module tb_fetch_prefetcher;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic [AW-1:0] o_wb_addr;
    logic          o_wb_cyc;
    logic [3:0]    o_wb_stb;
    logic          o_wb_we;
    logic [31:0]   o_wb_dat;
    logic [31:0]   i_wb_dat;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic          i_redirect;
    logic [AW-1:0] i_redirect_pc;
    logic          i_take;
    logic          o_valid;
    logic [15:0]   o_instruction;
    logic [31:0]   o_immediate;
    logic [3:0]    o_rb_idx;
    logic          o_rb_idx_valid;
    logic [AW-1:0] o_pc;
    logic [AW-1:0] o_next_pc;
    logic          o_error;

    always #5 i_clk = ~i_clk;

    fetch_prefetcher #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_wb_addr      (o_wb_addr),
        .o_wb_cyc       (o_wb_cyc),
        .o_wb_stb       (o_wb_stb),
        .o_wb_we        (o_wb_we),
        .o_wb_dat       (o_wb_dat),
        .i_wb_dat       (i_wb_dat),
        .i_wb_ack       (i_wb_ack),
        .i_wb_err       (i_wb_err),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_take         (i_take),
        .o_valid        (o_valid),
        .o_instruction  (o_instruction),
        .o_immediate    (o_immediate),
        .o_rb_idx       (o_rb_idx),
        .o_rb_idx_valid (o_rb_idx_valid),
        .o_pc           (o_pc),
        .o_next_pc      (o_next_pc),
        .o_error        (o_error)
    );

    // Instruction memory: 512 halfwords, byte address bits [9:1] select the entry.
    logic [15:0] mem [512];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input int unsigned addr);
        return mem[(addr >> 1) % 512];
    endfunction

    function automatic logic [31:0] word_at(input int unsigned addr);
        return {hw_at(addr), hw_at(addr + 2)};
    endfunction

    task automatic set_hw(input int unsigned addr, input logic [15:0] val);
        mem[(addr >> 1) % 512] = val;
    endtask

    // Reference decode straight from the instruction format.
    function automatic int unsigned ref_len(input logic [15:0] op);
        case (op[2:0])
            3'd1:       return 2;
            3'd2, 3'd3: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input int unsigned pc);
        logic [15:0] op;
        int a;
        int b;
        int v;
        op = hw_at(pc);
        a  = int'(hw_at(pc + 2));
        b  = int'(hw_at(pc + 4));
        case (op[2:0])
            3'd1: begin
                v = a % 4096;
                if (v >= 2048) v -= 4096;
                return 32'(v);
            end
            3'd2: begin
                v = (a % 4096) * 65536 + b;
                if (v >= 134217728) v -= 268435456;
                return 32'(v);
            end
            3'd3:    return word_at(pc + 2);
            default: return 32'd0;
        endcase
    endfunction

    task automatic redirect_to(input int unsigned pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        @(negedge i_clk);
        i_redirect    = 1'b0;
    endtask

    task automatic wait_cyc(input string tag);
        int n;
        n = 0;
        while (!o_wb_cyc && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check_eq({tag, "_cyc"}, 64'(o_wb_cyc), 64'(1));
    endtask

    task automatic bus_ack(input logic [31:0] data);
        i_wb_ack = 1'b1;
        i_wb_dat = data;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned model_pc;
        int unsigned new_pc;
        int unsigned bus_wait;
        int          stall;
        logic [15:0] h;

        i_reset       = 1'b1;
        i_wb_dat      = '0;
        i_wb_ack      = 1'b0;
        i_wb_err      = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_take        = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 16'd0;

        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        check_eq("rst_valid", 64'({o_valid, o_error, o_rb_idx_valid, o_wb_cyc}), 64'(0));
        check_eq("rst_bus", 64'({o_wb_addr, o_wb_stb, o_wb_we}), 64'(0));
        check_eq("rst_pc", 64'({o_pc, o_next_pc}), 64'(0));
        check_eq("rst_dec", 64'({o_instruction, o_immediate, o_rb_idx}), 64'(0));
        check_eq("rst_wdat", 64'(o_wb_dat), 64'(0));
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("no_fetch_before_redirect", 64'(o_wb_cyc), 64'(0));

        // NOIM pair at 0x100: valid two cycles after redirect
        set_hw(32'h100, 16'h0008);
        set_hw(32'h102, 16'h0000);
        redirect_to(32'h100);
        check_eq("t1_cyc", 64'(o_wb_cyc), 64'(1));
        check_eq("t1_addr", 64'(o_wb_addr), 64'h100);
        check_eq("t1_stb", 64'(o_wb_stb), 64'hF);
        bus_ack(word_at(32'h100));
        check_eq("t1_valid", 64'(o_valid), 64'(1));
        check_eq("t1_pc", 64'(o_pc), 64'h100);
        check_eq("t1_next", 64'(o_next_pc), 64'h102);
        check_eq("t1_instr", 64'(o_instruction), 64'h0008);
        i_take = 1'b1;
        @(negedge i_clk);
        i_take = 1'b0;
        check_eq("t1_pc2", 64'(o_pc), 64'h102);
        check_eq("t1_valid2", 64'(o_valid), 64'(1));

        // Odd redirect: single-halfword push then IM12 completes
        set_hw(32'h100, 16'hAAAA);
        set_hw(32'h102, 16'h0001);
        set_hw(32'h104, 16'h8923);
        set_hw(32'h106, 16'h5555);
        redirect_to(32'h102);
        wait_cyc("t2a");
        check_eq("t2_addr", 64'(o_wb_addr), 64'h100);
        check_eq("t2_stb", 64'(o_wb_stb), 64'h3);
        bus_ack(word_at(32'h100));
        check_eq("t2_partial", 64'(o_valid), 64'(0));
        wait_cyc("t2b");
        check_eq("t2_addr2", 64'(o_wb_addr), 64'h104);
        check_eq("t2_stb2", 64'(o_wb_stb), 64'hF);
        bus_ack(word_at(32'h104));
        check_eq("t2_valid", 64'(o_valid), 64'(1));
        check_eq("t2_pc", 64'(o_pc), 64'h102);
        check_eq("t2_imm", 64'(o_immediate), 64'hFFFF_F923);
        check_eq("t2_rb", 64'(o_rb_idx), 64'h8);
        check_eq("t2_rbv", 64'(o_rb_idx_valid), 64'(1));
        check_eq("t2_next", 64'(o_next_pc), 64'h106);

        // IM32 with slow acks
        set_hw(32'h200, 16'h0003);
        set_hw(32'h202, 16'hDEAD);
        set_hw(32'h204, 16'hBEEF);
        set_hw(32'h206, 16'h0000);
        redirect_to(32'h200);
        wait_cyc("t3a");
        repeat (3) @(negedge i_clk);
        check_eq("t3_hold_addr", 64'({o_wb_cyc, o_wb_addr}), 64'({1'b1, 32'h200}));
        check_eq("t3_empty", 64'(o_valid), 64'(0));
        bus_ack(word_at(32'h200));
        check_eq("t3_two", 64'(o_valid), 64'(0));
        wait_cyc("t3b");
        repeat (3) @(negedge i_clk);
        check_eq("t3_two_wait", 64'(o_valid), 64'(0));
        bus_ack(word_at(32'h204));
        check_eq("t3_valid", 64'(o_valid), 64'(1));
        check_eq("t3_imm", 64'(o_immediate), 64'hDEAD_BEEF);
        check_eq("t3_next", 64'(o_next_pc), 64'h206);
        check_eq("t3_rbv", 64'(o_rb_idx_valid), 64'(0));

        // Bus error on the second word
        set_hw(32'h300, 16'h0010);
        set_hw(32'h302, 16'h0020);
        redirect_to(32'h300);
        wait_cyc("t4a");
        bus_ack(word_at(32'h300));
        wait_cyc("t4b");
        i_wb_err = 1'b1;
        @(negedge i_clk);
        i_wb_err = 1'b0;
        check_eq("t4_cyc_drop", 64'(o_wb_cyc), 64'(0));
        check_eq("t4_drain_valid", 64'({o_valid, o_error}), 64'({1'b1, 1'b0}));
        check_eq("t4_pc", 64'(o_pc), 64'h300);
        i_take = 1'b1;
        @(negedge i_clk);
        check_eq("t4_pc2", 64'({o_valid, o_pc}), 64'({1'b1, 32'h302}));
        @(negedge i_clk);
        i_take = 1'b0;
        check_eq("t4_error", 64'({o_valid, o_error}), 64'({1'b0, 1'b1}));
        repeat (3) @(negedge i_clk);
        check_eq("t4_stopped", 64'({o_wb_cyc, o_error}), 64'({1'b0, 1'b1}));
        set_hw(32'h000, 16'h0000);
        set_hw(32'h002, 16'h0000);
        redirect_to(32'h000);
        check_eq("t4_clear", 64'({o_wb_cyc, o_error}), 64'({1'b1, 1'b0}));

        // Redirect together with ack and take
        bus_ack(word_at(32'h000));
        check_eq("t5_valid", 64'(o_valid), 64'(1));
        wait_cyc("t5");
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h400;
        i_wb_ack      = 1'b1;
        i_wb_dat      = 32'h1234_5678;
        i_take        = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b0;
        i_wb_ack   = 1'b0;
        i_take     = 1'b0;
        check_eq("t5_flush", 64'({o_valid, o_wb_cyc}), 64'(0));
        check_eq("t5_pc", 64'(o_pc), 64'h400);
        @(negedge i_clk);
        check_eq("t5_restart", 64'({o_wb_cyc, o_wb_addr}), 64'({1'b1, 32'h400}));

        // Asynchronous reset in the middle of a bus cycle
        #2 i_reset = 1'b1;
        #1;
        check_eq("t6_async_bus", 64'({o_wb_cyc, o_wb_stb, o_wb_addr}), 64'(0));
        check_eq("t6_async_out", 64'({o_valid, o_error, o_pc}), 64'(0));
        @(negedge i_clk);
        i_reset  = 1'b0;
        i_wb_ack = 1'b1;
        i_wb_dat = 32'h0000_0000;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        @(negedge i_clk);
        check_eq("t6_late_ack", 64'({o_valid, o_wb_cyc}), 64'(0));

        // Randomized stream against the reference model
        for (int i = 0; i < 512; i++) begin
            h      = 16'($urandom);
            h[15]  = h[11];
            mem[i] = h;
        end
        new_pc   = $urandom_range(0, 511) * 2;
        model_pc = new_pc;
        bus_wait = 0;
        stall    = 0;
        redirect_to(new_pc);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (o_valid) begin
                stall = 0;
                check_eq("r_pc", 64'(o_pc), 64'(model_pc));
                check_eq("r_instr", 64'(o_instruction), 64'(hw_at(model_pc)));
                check_eq("r_imm", 64'(o_immediate), 64'(ref_imm(model_pc)));
                check_eq("r_next", 64'(o_next_pc),
                         64'(model_pc + 2 * ref_len(hw_at(model_pc))));
                check_eq("r_rbv", 64'(o_rb_idx_valid),
                         64'(hw_at(model_pc) % 8 == 1 || hw_at(model_pc) % 8 == 2));
                if (o_rb_idx_valid) begin
                    check_eq("r_rb", 64'(o_rb_idx), 64'(hw_at(model_pc + 2) >> 12));
                end
            end else begin
                stall++;
            end
            check_eq("r_stall", 64'(stall > 30), 64'(0));
            check_eq("r_error", 64'(o_error), 64'(0));

            i_wb_ack = 1'b0;
            if (o_wb_cyc) begin
                if (bus_wait == 0) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = word_at(o_wb_addr);
                    bus_wait = $urandom_range(0, 3);
                end else begin
                    bus_wait--;
                end
            end

            i_take = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                new_pc        = $urandom_range(0, 511) * 2;
                i_redirect    = 1'b1;
                i_redirect_pc = new_pc | $urandom_range(0, 1);
                model_pc      = new_pc;
                stall         = 0;
            end else begin
                i_redirect = 1'b0;
                if (i_take && o_valid) begin
                    model_pc += 2 * ref_len(hw_at(model_pc));
                end
            end
            @(negedge i_clk);
        end
        i_redirect = 1'b0;
        i_take     = 1'b0;
        i_wb_ack   = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
